// File: rtl/grid_game_pkg.sv
// Shared types and helpers for the grid game engine: state encoding,
// LFSR tap table and small bitmap helpers.
package grid_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Galois tap masks (right-shifting form), bit k-1 set for each x^k term.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return {32'h0, LFSR_TAPS_32};
            40:      return 64'h0000_00A0_0014_0000;
            48:      return 64'h0000_C000_0018_0000;
            default: return {32'h0, LFSR_TAPS_32};
        endcase
    endfunction

    function automatic logic [15:0] onehot16(input logic [7:0] idx);
        logic [15:0] r;
        r = '0;
        if (idx < 8'd16) r[idx[3:0]] = 1'b1;
        return r;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR; advances every clock, reloads SEED on reset.
module lfsr_gen
    import grid_game_pkg::*;
#(
    parameter int           W    = 32,
    parameter logic [W-1:0] SEED = W'(32'hACE1_1234)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] q
);

    localparam logic [63:0]  TAPS_ALL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[W-1:1]} ^ (q_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= SEED;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/grid_game_engine.sv
// Fire/gold grid game controller: tick-paced rounds, LFSR patterns with a
// one-round fire look-ahead, saturating score/life and loss-priority ending.
module grid_game_engine
    import grid_game_pkg::*;
#(
    parameter int                NUM_CELLS = 9,
    parameter int                LIFE_MAX  = 3,
    parameter int                LIFE_W    = 2,
    parameter int                WIN_SCORE = 15,
    parameter int                SCORE_W   = 4,
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(32'hACE1_1234)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 super_en,
    input  logic [NUM_CELLS-1:0] box,
    output logic [1:0]           game_state,
    output logic [SCORE_W-1:0]   score,
    output logic [LIFE_W-1:0]    life,
    output logic [NUM_CELLS-1:0] fire_state,
    output logic [NUM_CELLS-1:0] gold_state,
    output logic [NUM_CELLS-1:0] next_fire_pattern,
    output logic [NUM_CELLS-1:0] hit_bitmap,
    output logic                 win
);

    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [LIFE_W-1:0]  LIFE_INIT = LIFE_W'(LIFE_MAX);
    localparam logic [7:0]         NC8       = 8'(NUM_CELLS);

    game_state_e          state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIFE_W-1:0]    life_q, life_d;
    logic [NUM_CELLS-1:0] fire_q, fire_d;
    logic [NUM_CELLS-1:0] gold_q, gold_d;
    logic [NUM_CELLS-1:0] next_fire_q, next_fire_d;
    logic [NUM_CELLS-1:0] hit_q, hit_d;
    logic                 win_q, win_d;

    logic [LFSR_W-1:0]    lfsr;
    logic [NUM_CELLS-1:0] cand_fire;
    logic [NUM_CELLS-1:0] cand_gold;
    logic [NUM_CELLS-1:0] miss;
    logic [7:0]           gold_raw;
    logic [7:0]           gold_idx;
    logic [15:0]          gold_oh_full;
    logic                 unused_bits;

    lfsr_gen #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Two disjoint slices ANDed give ~25% fire density per cell.
    assign cand_fire    = lfsr[NUM_CELLS-1:0] & lfsr[2*NUM_CELLS-1:NUM_CELLS];
    assign gold_raw     = lfsr[2*NUM_CELLS+7 -: 8];
    assign gold_idx     = gold_raw % NC8;
    assign gold_oh_full = onehot16(gold_idx);
    assign cand_gold    = gold_oh_full[NUM_CELLS-1:0];
    assign miss         = fire_q & ~box;
    assign unused_bits  = ^{lfsr, gold_oh_full};

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        life_d      = life_q;
        fire_d      = fire_q;
        gold_d      = gold_q;
        next_fire_d = next_fire_q;
        hit_d       = hit_q;
        win_d       = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PLAY;
                    score_d     = '0;
                    life_d      = LIFE_INIT;
                    win_d       = 1'b0;
                    hit_d       = '0;
                    fire_d      = '0;
                    gold_d      = '0;
                    next_fire_d = cand_fire;
                end
            end
            ST_PLAY: begin
                // End checks see the values written by the previous tick; loss first.
                if (life_q == '0) begin
                    state_d     = ST_OVER;
                    win_d       = 1'b0;
                    fire_d      = '0;
                    gold_d      = '0;
                    next_fire_d = '0;
                end else if (score_q == WIN_S) begin
                    state_d     = ST_OVER;
                    win_d       = 1'b1;
                    fire_d      = '0;
                    gold_d      = '0;
                    next_fire_d = '0;
                end else if (tick) begin
                    hit_d = miss;
                    if ((miss != '0) && !super_en) life_d = life_q - 1'b1;
                    if (((gold_q & box) != '0) && (score_q != WIN_S)) score_d = score_q + 1'b1;
                    fire_d      = next_fire_q;
                    next_fire_d = cand_fire;
                    // Gold is dropped rather than placed under next round's fire.
                    gold_d      = ((cand_gold & next_fire_q) != '0) ? '0 : cand_gold;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d = ST_IDLE;
                    win_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            life_q      <= LIFE_INIT;
            fire_q      <= '0;
            gold_q      <= '0;
            next_fire_q <= '0;
            hit_q       <= '0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            life_q      <= life_d;
            fire_q      <= fire_d;
            gold_q      <= gold_d;
            next_fire_q <= next_fire_d;
            hit_q       <= hit_d;
            win_q       <= win_d;
        end
    end

    assign game_state        = state_q;
    assign score             = score_q;
    assign life              = life_q;
    assign fire_state        = fire_q;
    assign gold_state        = gold_q;
    assign next_fire_pattern = next_fire_q;
    assign hit_bitmap        = hit_q;
    assign win               = win_q;

endmodule

// File: tb/tb_grid_game_engine.sv
// Directed bench for grid_game_engine with a cycle-level reference model.
module tb_grid_game_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start;
    logic       super_en;
    logic [8:0] box;
    logic [1:0] game_state;
    logic [3:0] score;
    logic [1:0] life;
    logic [8:0] fire_state;
    logic [8:0] gold_state;
    logic [8:0] next_fire_pattern;
    logic [8:0] hit_bitmap;
    logic       win;

    int checks   = 0;
    int failures = 0;

    logic [31:0] lfsr_m;
    int          e_state;
    logic [3:0]  e_score;
    logic [1:0]  e_life;
    logic [8:0]  e_fire, e_gold, e_nf, e_hit;
    logic        e_win;

    always #5 clk = ~clk;

    grid_game_engine dut (
        .clk               (clk),
        .rst               (rst),
        .tick              (tick),
        .start             (start),
        .super_en          (super_en),
        .box               (box),
        .game_state        (game_state),
        .score             (score),
        .life              (life),
        .fire_state        (fire_state),
        .gold_state        (gold_state),
        .next_fire_pattern (next_fire_pattern),
        .hit_bitmap        (hit_bitmap),
        .win               (win)
    );

    // Reference RNG: x^32+x^22+x^2+x+1, Galois right shift.
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 32'hACE1_1234;
        else      lfsr_m <= {1'b0, lfsr_m[31:1]} ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_state = 0; e_score = 4'd0; e_life = 2'd3;
        e_fire = '0; e_gold = '0; e_nf = '0; e_hit = '0; e_win = 1'b0;
    endtask

    task automatic check_all(input string w);
        chk({w, ".state"}, 32'(game_state), 32'(e_state));
        chk({w, ".score"}, 32'(score), 32'(e_score));
        chk({w, ".life"}, 32'(life), 32'(e_life));
        chk({w, ".fire"}, 32'(fire_state), 32'(e_fire));
        chk({w, ".gold"}, 32'(gold_state), 32'(e_gold));
        chk({w, ".next_fire"}, 32'(next_fire_pattern), 32'(e_nf));
        chk({w, ".hit"}, 32'(hit_bitmap), 32'(e_hit));
        chk({w, ".win"}, 32'(win), 32'(e_win));
    endtask

    // One clock cycle: drive inputs, advance the model, then compare.
    task automatic cyc(input string w, input logic t, input logic s, input logic [8:0] b, input logic sp);
        logic [31:0] l;
        logic [8:0]  cf, oh, miss;
        int          gi;
        tick = t; start = s; box = b; super_en = sp;
        l  = lfsr_m;
        cf = 9'h0;
        for (int k = 0; k < 9; k++) cf[k] = l[k] & l[k+9];
        gi = int'(l[25:18]) % 9;
        oh = 9'd1 << gi;
        case (e_state)
            0: if (s) begin
                e_state = 1; e_score = 4'd0; e_life = 2'd3; e_win = 1'b0;
                e_hit = '0; e_fire = '0; e_gold = '0; e_nf = cf;
            end
            1: if (e_life == 2'd0) begin
                e_state = 2; e_win = 1'b0; e_fire = '0; e_gold = '0; e_nf = '0;
            end else if (e_score == 4'd15) begin
                e_state = 2; e_win = 1'b1; e_fire = '0; e_gold = '0; e_nf = '0;
            end else if (t) begin
                miss  = e_fire & ~b;
                e_hit = miss;
                if (miss != 9'h0 && !sp) e_life = e_life - 2'd1;
                if ((e_gold & b) != 9'h0 && e_score != 4'd15) e_score = e_score + 4'd1;
                e_gold = ((oh & e_nf) != 9'h0) ? 9'h0 : oh;
                e_fire = e_nf;
                e_nf   = cf;
            end
            default: if (s) begin
                e_state = 0; e_win = 1'b0;
            end
        endcase
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0;
        check_all(w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] last_fire;
        logic [8:0] bx;
        logic       found;
        tick = 1'b0; start = 1'b0; super_en = 1'b0; box = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        #10;
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_life", 32'(life), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_bitmaps", 32'({fire_state, gold_state, next_fire_pattern, hit_bitmap}), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        @(negedge clk) rst = 1'b1;

        cyc("idle", 1'b1, 1'b0, 9'h1FF, 1'b0);
        cyc("idle", 1'b0, 1'b0, 9'h000, 1'b0);
        cyc("start", 1'b0, 1'b1, 9'h000, 1'b0);
        chk("start_state", 32'(game_state), 32'd1);
        chk("start_life", 32'(life), 32'd3);
        chk("start_fire", 32'(fire_state), 32'd0);

        // All cells covered: no hits, gold accumulates until the win.
        for (int i = 0; i < 100 && e_state != 2; i++) begin
            if (i % 4 == 3) cyc("gold_idle", 1'b0, 1'b1, 9'h0AA, 1'b0);
            else            cyc("gold", 1'b1, 1'b0, 9'h1FF, 1'b0);
            chk("gold_life", 32'(life), 32'd3);
            chk("gold_hit", 32'(hit_bitmap), 32'd0);
        end
        chk("win_state", 32'(game_state), 32'd2);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_score", 32'(score), 32'd15);
        cyc("over_tick", 1'b1, 1'b0, 9'h000, 1'b0);
        cyc("over_start", 1'b1, 1'b1, 9'h000, 1'b0);
        chk("idle_win", 32'(win), 32'd0);
        chk("idle_score_held", 32'(score), 32'd15);
        cyc("restart", 1'b1, 1'b1, 9'h000, 1'b0);
        chk("restart_life", 32'(life), 32'd3);
        chk("restart_score", 32'(score), 32'd0);

        // Nothing covered: every fire round costs a life.
        last_fire = '0;
        for (int i = 0; i < 200 && e_state != 2; i++) begin
            if (e_state == 1 && e_life == 2'd1 && e_fire != 9'h0) last_fire = e_fire;
            cyc("loss", 1'b1, 1'b0, 9'h000, 1'b0);
        end
        chk("loss_state", 32'(game_state), 32'd2);
        chk("loss_life", 32'(life), 32'd0);
        chk("loss_win", 32'(win), 32'd0);
        chk("loss_hit", 32'(hit_bitmap), 32'(last_fire));
        chk("loss_cleared", 32'({fire_state, gold_state, next_fire_pattern}), 32'd0);

        cyc("to_idle", 1'b0, 1'b1, 9'h000, 1'b0);
        cyc("to_play", 1'b0, 1'b1, 9'h000, 1'b0);
        for (int i = 0; i < 50; i++) cyc("super", 1'b1, 1'b0, 9'h000, 1'b1);
        chk("super_life", 32'(life), 32'd3);
        chk("super_state", 32'(game_state), 32'd1);

        // Steer to score 14 / life 1, then collect gold while missing fire.
        found = 1'b0;
        for (int i = 0; i < 400 && !found && e_state == 1; i++) begin
            if (e_life == 2'd1 && e_score == 4'd14 && e_fire != 9'h0 && e_gold != 9'h0) begin
                found = 1'b1;
                bx    = e_gold;
            end else begin
                bx = ((e_score < 4'd14) ? e_gold : 9'h0) |
                     ((e_life > 2'd1 && e_fire != 9'h0) ? 9'h0 : e_fire);
            end
            cyc("prio_setup", 1'b1, 1'b0, bx, 1'b0);
        end
        chk("prio_found", 32'(found), 32'd1);
        cyc("prio_end", 1'b0, 1'b0, 9'h000, 1'b0);
        chk("prio_state", 32'(game_state), 32'd2);
        chk("prio_win", 32'(win), 32'd0);
        chk("prio_score", 32'(score), 32'd15);
        chk("prio_life", 32'(life), 32'd0);

        cyc("r_idle", 1'b0, 1'b1, 9'h000, 1'b0);
        cyc("r_play", 1'b0, 1'b1, 9'h000, 1'b0);
        for (int i = 0; i < 3; i++) cyc("r_run", 1'b1, 1'b0, 9'h000, 1'b1);
        rst = 1'b0;
        #2;
        model_reset();
        chk("arst_state", 32'(game_state), 32'd0);
        chk("arst_life", 32'(life), 32'd3);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_bitmaps", 32'({fire_state, gold_state, next_fire_pattern, hit_bitmap}), 32'd0);
        chk("arst_win", 32'(win), 32'd0);
        @(negedge clk) rst = 1'b1;
        cyc("post_rst", 1'b0, 1'b1, 9'h000, 1'b0);
        chk("post_rst_state", 32'(game_state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
